// File: rtl/shared_reg_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// shared_reg_arb_pkg
// Common definitions for the shared register arbiter slice:
//   - arb_state_e : ownership FSM states (IDLE, OWN)
//   - N_DEF / W_DEF / HOLD_MAX_DEF : default parameter values
//   - idx_t       : requester index type (wide enough for up to MAX_N requesters)
//   - rr_inc()    : round-robin index increment with wrap at n
// ----------------------------------------------------------------------------
package shared_reg_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int HOLD_MAX_DEF = 4;
  localparam int MAX_N        = 8;

  typedef logic [2:0] idx_t;

  // Next index in round-robin order, wrapping from n-1 back to 0.
  function automatic idx_t rr_inc(input idx_t idx, input int n);
    if (int'(idx) >= n - 1) begin
      return 3'd0;
    end else begin
      return idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter_if
// Bundles the requester-side bus of the shared register arbiter.
//   req     : level request per requester
//   wr_en   : write strobe per requester (honoured only while granted)
//   wr_data : flattened write data, requester i at [i*W +: W]
//   gnt     : one-hot registered grant
//   busy    : any grant active
//   q       : shared register contents
//   tmo     : forced-release pulse
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface shared_reg_arbiter_if
  import shared_reg_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);

  logic [N-1:0]   req;
  logic [N-1:0]   wr_en;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   q;
  logic           tmo;

  modport master (
    output req, wr_en, wr_data,
    input  gnt, busy, q, tmo
  );

  modport slave (
    input  req, wr_en, wr_data,
    output gnt, busy, q, tmo
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req starting one past `last`
// and wrapping, returning the first set requester.
//   req    : request vector
//   last   : index of the most recent winner
//   winner : selected index (0 when valid is low)
//   valid  : at least one request present
// ----------------------------------------------------------------------------
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] req,
  input  idx_t         last,
  output idx_t         winner,
  output logic         valid
);

  logic [MAX_N-1:0] req_ext_s;
  idx_t             cand_s;

  // Zero-extend req so any idx_t value can index it safely.
  always_comb begin
    req_ext_s        = '0;
    req_ext_s[N-1:0] = req;
  end

  // Walk the ring once from last+1, keeping the first hit.
  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    cand_s = last;
    for (int k = 0; k < N; k++) begin
      cand_s = rr_inc(cand_s, N);
      if (!valid && req_ext_s[cand_s]) begin
        valid  = 1'b1;
        winner = cand_s;
      end else begin
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin arbiter that serialises writes from N requesters into a single
// W-bit shared register. Grants are one-hot and registered; at least one idle
// cycle separates consecutive grants.
// Ports:
//   ck    : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : shared_reg_arbiter_if.slave (req, wr_en, wr_data, gnt, busy, q, tmo)
// Build option:
//   SHARED_REG_ARB_TIMEOUT_EN - when defined, an ownership is force-released
//   after HOLD_MAX grant cycles and tmo pulses; otherwise tmo stays 0 and the
//   owner keeps the grant until it drops req.
// ----------------------------------------------------------------------------
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                  ck,
  input  logic                  rst_n,
  shared_reg_arbiter_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'(ST_IDLE);
  localparam logic [0:0] OWN  = 1'(ST_OWN);

  logic [0:0]   state_r, state_n;
  logic [N-1:0] gnt_r, gnt_n;
  logic         busy_r, busy_n;
  logic         tmo_r, tmo_n;
  idx_t         last_r, last_n;
  logic [W-1:0] q_r;

  idx_t         pick_winner_s;
  logic         pick_valid_s;
  logic [N-1:0] onehot_s;
  logic         owner_req_s;
  logic         wr_hit_s;
  logic [W-1:0] wr_word_s;

`ifdef SHARED_REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_r, cnt_n;
`else
  logic unused_hold_s;
  assign unused_hold_s = ^HOLD_MAX;
`endif

  rr_pick #(.N(N)) u_rr_pick (
    .req    (bus.req),
    .last   (last_r),
    .winner (pick_winner_s),
    .valid  (pick_valid_s)
  );

  // Decode the picked index into a one-hot grant vector.
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < N; i++) begin
      onehot_s[i] = (idx_t'(i) == pick_winner_s);
    end
  end

  // Owner's request and write strobe, using the registered grant as the mask.
  always_comb begin
    owner_req_s = |(bus.req & gnt_r);
    wr_hit_s    = (state_r == OWN) && (|(bus.wr_en & gnt_r));
    wr_word_s   = q_r;
    for (int i = 0; i < N; i++) begin
      if (gnt_r[i]) begin
        wr_word_s = bus.wr_data[i*W +: W];
      end else begin
      end
    end
  end

  // Ownership FSM next-state logic.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    busy_n  = busy_r;
    last_n  = last_r;
    tmo_n   = 1'b0;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
    cnt_n   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_n = OWN;
          gnt_n   = onehot_s;
          busy_n  = 1'b1;
          last_n  = pick_winner_s;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
          cnt_n   = CW'(1);
`endif
        end else begin
          gnt_n  = '0;
          busy_n = 1'b0;
        end
      end
      OWN: begin
        if (!owner_req_s) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
        end else if (cnt_r == CW'(HOLD_MAX)) begin
          // Forced release; last already points at this owner so others go first.
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
`else
        end else begin
          state_n = OWN;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, grant and shared register bank; reset clears everything including q.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      busy_r  <= 1'b0;
      tmo_r   <= 1'b0;
      last_r  <= idx_t'(N - 1);
      q_r     <= '0;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
      cnt_r   <= '0;
`endif
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      busy_r  <= busy_n;
      tmo_r   <= tmo_n;
      last_r  <= last_n;
      if (wr_hit_s) begin
        q_r <= wr_word_s;
      end else begin
        q_r <= q_r;
      end
`ifdef SHARED_REG_ARB_TIMEOUT_EN
      cnt_r   <= cnt_n;
`endif
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.busy = busy_r;
  assign bus.q    = q_r;
  assign bus.tmo  = tmo_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Self-checking bench for shared_reg_arbiter. A behavioural model tracks the
// owner as an integer, searches the ring with modular arithmetic and applies
// writes, releases and timeouts per cycle; outputs are compared 1 time unit
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int HM = 4;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int VW = N + W + 2;

  logic ck;
  logic rst_n;
  int   checks;
  int   errors;

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

  shared_reg_arbiter #(.N(N), .W(W), .HOLD_MAX(HM)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // ---------------- reference model ----------------
  int           m_owner;   // -1 when nobody owns
  int           m_last;
  int           m_cnt;
  logic [W-1:0] m_q;
  logic         m_tmo;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_gnt(), (m_owner >= 0), m_q, m_tmo};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.gnt, bus.busy, bus.q, bus.tmo};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    m_q     = '0;
    m_tmo   = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently on the bus.
  task automatic model_edge();
    int c;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_last + 1 + k) % N;
        if (m_owner < 0 && bus.req[c]) begin
          m_owner = c;
          m_last  = c;
          m_cnt   = 1;
        end
      end
    end else begin
      m_tmo = 1'b0;
      if (bus.wr_en[m_owner]) m_q = bus.wr_data[m_owner*W +: W];
      if (!bus.req[m_owner]) begin
        m_owner = -1;
      end else if (TMO_EN && m_cnt == HM) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge ck);
    model_edge();
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    bus.wr_data[i*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.wr_en = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.wr_en = '0;
    bus.wr_data = '0;
    tick();
    tick();
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), {VW{1'b0}});
    end
    rst_n = 1'b1;
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1 || bus.q !== 8'h00) begin
      errors++;
      $display("FAIL first_grant got gnt=%b busy=%b q=%h exp gnt=0100 busy=1 q=00",
               bus.gnt, bus.busy, bus.q);
    end
  endtask

  task automatic test_write_release();
    bus.wr_en = 4'b0100;
    set_data(2, 8'hA5);
    tick();
    checks++;
    if (bus.q !== 8'hA5 || bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL owner_write got q=%h gnt=%b exp q=a5 gnt=0100", bus.q, bus.gnt);
    end
    bus.wr_en = '0;
    bus.req = '0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin
      errors++;
      $display("FAIL release got gnt=%b busy=%b q=%h exp gnt=0000 busy=0 q=a5",
               bus.gnt, bus.busy, bus.q);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int grant_cyc[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.req = 4'b1111 & ~exp_gnt();
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_cycle %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          order.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_count got %0d exp 5", order.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (order[j] != exp_order[j] || grant_cyc[j] != 2 * j) begin
          errors++;
          $display("FAIL rr_order idx %0d got req %0d at cyc %0d exp req %0d at cyc %0d",
                   j, order[j], grant_cyc[j], exp_order[j], 2 * j);
        end
      end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_nonowner_write();
    logic [W-1:0] q_before;
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.wr_en = 4'b0010;
    set_data(1, 8'h5A);
    tick();
    q_before = bus.q;
    checks++;
    if (q_before !== 8'h5A) begin
      errors++;
      $display("FAIL owner1_write got q=%h exp 5a", q_before);
    end
    bus.wr_en = 4'b0001;
    set_data(0, 8'h3C);
    tick();
    checks++;
    if (bus.q !== 8'h5A || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL nonowner_write got q=%h exp 5a", bus.q);
    end
    bus.wr_en = '0;
    bus.req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int g0_cycles;
    int tmo_cycles;
    int tmo_at;
    int first_g3;
    g0_cycles = 0;
    tmo_cycles = 0;
    tmo_at = -1;
    first_g3 = -1;
    do_reset();
    bus.req = 4'b0001;
    for (int cyc = 0; cyc < 14; cyc++) begin
      tick();
      bus.req = 4'b1001;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tmo_cycle %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
      if (bus.gnt[0] === 1'b1) g0_cycles++;
      if (bus.tmo === 1'b1) begin
        tmo_cycles++;
        if (tmo_at < 0) tmo_at = cyc;
      end
      if (bus.gnt[3] === 1'b1 && first_g3 < 0) first_g3 = cyc;
    end
    checks++;
    if (TMO_EN) begin
      if (g0_cycles != HM || tmo_cycles != 1 || tmo_at != HM || first_g3 != HM + 1) begin
        errors++;
        $display("FAIL timeout got g0=%0d tmo=%0d tmo_at=%0d g3_at=%0d exp g0=%0d tmo=1 tmo_at=%0d g3_at=%0d",
                 g0_cycles, tmo_cycles, tmo_at, first_g3, HM, HM, HM + 1);
      end
    end else begin
      if (g0_cycles != 14 || tmo_cycles != 0 || first_g3 != -1) begin
        errors++;
        $display("FAIL no_timeout got g0=%0d tmo=%0d g3_at=%0d exp g0=14 tmo=0 g3_at=-1",
                 g0_cycles, tmo_cycles, first_g3);
      end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.wr_en = 4'b0010;
    set_data(1, 8'h7E);
    tick();
    bus.wr_en = '0;
    checks++;
    if (bus.q !== 8'h7E || bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_setup got q=%h gnt=%b exp q=7e gnt=0010", bus.q, bus.gnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.q !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got gnt=%b q=%h busy=%b exp gnt=0000 q=00 busy=0",
               bus.gnt, bus.q, bus.busy);
    end
    bus.req = 4'b0011;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_pick got gnt=%b exp 0001", bus.gnt);
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_random();
    int local_err;
    local_err = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      bus.req = N'($urandom);
      // Keep the owner's request mostly high so ownerships last several cycles.
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) bus.req[m_owner] = 1'b1;
      bus.wr_en = N'($urandom);
      bus.wr_data = (N*W)'({$urandom, $urandom});
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        local_err++;
        if (local_err < 10)
          $display("FAIL random cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
    bus.req = '0;
    bus.wr_en = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.wr_en = '0;
    bus.wr_data = '0;
    test_reset();
    test_write_release();
    test_round_robin();
    test_nonowner_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
